cpu_run_ctrl: RTL and testbench
===============================

# cpu_run_ctrl

Run-control sequencer for the single-cycle CPU clock path. From the board clock it produces a one-cycle clock-enable pulse (`cpu_ce`) at a selectable rate and sequences CPU execution through stopped, free-run, single-step, halted and resume modes. It sits between the board buttons/switches and the CPU datapath, replacing free-running divided clocks with a single-clock-domain enable scheme.

## Interface
- `DIV0`, 4: clocks per `cpu_ce` in RUN when `freq_sel`=0 (≥2)
- `DIV1`, 100: ratio for `freq_sel`=1
- `DIV2`, 1000: ratio for `freq_sel`=2
- `DIV3`, 50000000: ratio for `freq_sel`=3
- `clk` input 1: system clock, all state on rising edge
- `rst_n` input 1: asynchronous active-low reset
- `go` input 1: run/resume request, level, rising edge acts
- `stop` input 1: stop request, level, rising edge acts
- `step` input 1: single-step request, level, rising edge acts
- `halt_req` input 1: CPU halt (syscall), level, sampled only in RUN
- `freq_sel` input 2: divide-ratio select
- `cpu_ce` output 1: registered CPU enable, one cycle per instruction
- `running` output 1: high in RUN
- `halted` output 1: high in HALT
- `state` output 2: IDLE=0, RUN=1, STEP=2, HALT=3
- `cycle_cnt` output 32: `cpu_ce` pulse count (only with macro, see Configuration)

## Operation
- Inputs are synchronous to `clk`. Edge detect: `x_rise = x & ~x_d`, `x_d` registered; `x_d` resets to 0 (level high out of reset does not trigger until seen low).
- Divider counter `cnt` (32 bit) active only in RUN; held 0 in all other states. `div` = DIV selected by `freq_sel`.
- IDLE: `go_rise` → RUN, `cnt`=0. `step_rise` → STEP, `cpu_ce`<=1.
- RUN: `cnt` increments; when `cnt >= div-1`: `cnt`<=0, `cpu_ce`<=1 for one cycle. `halt_req` → HALT. `stop_rise` → IDLE. `step_rise`/`go_rise` ignored.
- STEP: `cpu_ce`<=0, → IDLE unconditionally (exactly one pulse per step edge).
- HALT: sticky. `go_rise` → RUN with `cpu_ce`<=1 (resume pulse moves CPU past the syscall), `cnt`=0; `halt_req` is masked on the first RUN cycle after resume. `stop_rise` → IDLE. `step_rise` ignored.
- Priority at one edge in RUN: `halt_req` > `stop_rise` > counter wrap; a halt or stop at the wrap edge suppresses that pulse. In IDLE, `go_rise` beats `step_rise`.
- `freq_sel` change takes effect immediately; the `>=` compare forces a wrap on the next edge if `cnt` already exceeds the new `div-1`.

## Timing
- Reset (async, `rst_n`=0): state=IDLE, `cnt`=0, `cpu_ce`=0, `running`=0, `halted`=0, `x_d`=0, `cycle_cnt`=0.
- `running`/`halted` decoded from registered state, valid the cycle state changes.
- RUN entry at edge k: first `cpu_ce` high during cycle after edge k+div; thereafter period exactly `div` clocks, width 1.
- Step: `step_rise` at edge k → `cpu_ce` high for the cycle after edge k only.
- Resume: `go_rise` at edge k in HALT → `cpu_ce` high after edge k; next pulse after edge k+div unless halted again.
- Reset asserted mid-operation aborts any pending pulse; `cpu_ce` drops asynchronously.

## Configuration
- `CPU_RUN_CTRL_CYCLE_CNT_EN` defined: `cycle_cnt` port and 32-bit counter present; increments on every cycle `cpu_ce` is high, wraps 0xFFFFFFFF→0, cleared only by reset.
- Not defined: port and counter absent; all other behaviour identical.

## Test plan
- Reset then `go` pulse, `freq_sel`=0 (DIV0=4) → `cpu_ce` pulses at edges k+4, k+8, k+12, each 1 cycle wide; `running`=1, `state`=1.
- In IDLE, three `step` pulses spaced 10 clocks → exactly three 1-cycle `cpu_ce` pulses, state IDLE→STEP→IDLE each; with macro `cycle_cnt`=3.
- RUN with `halt_req` asserted on a wrap edge → no pulse, `halted`=1; `go` pulse → one immediate `cpu_ce`, `halt_req` ignored that cycle, next pulse 4 clocks later.
- RUN with `freq_sel`=1, `cnt`=60, switch to `freq_sel`=0 → pulse on next edge, then period 4.
- `stop` and `go` both rising in same RUN cycle → IDLE, no pulse; `go` held high afterwards → no restart until dropped and reasserted.
- `rst_n` low mid-RUN with `cnt`=2 → `cpu_ce`=0, state IDLE immediately; after release no pulses without `go`.

Source files
------------

// File: rtl/cpu_run_ctrl_if.sv
// Run-control bundle between board controls and the CPU clock-enable sequencer.
// CPU_RUN_CTRL_CYCLE_CNT_EN adds the cycle_cnt pulse counter signal.
interface cpu_run_ctrl_if;
  logic        go;
  logic        stop;
  logic        step;
  logic        halt_req;
  logic [1:0]  freq_sel;
  logic        cpu_ce;
  logic        running;
  logic        halted;
  logic [1:0]  state;
`ifdef CPU_RUN_CTRL_CYCLE_CNT_EN
  logic [31:0] cycle_cnt;
`endif

  modport master (
`ifdef CPU_RUN_CTRL_CYCLE_CNT_EN
    input  cycle_cnt,
`endif
    output go,
    output stop,
    output step,
    output halt_req,
    output freq_sel,
    input  cpu_ce,
    input  running,
    input  halted,
    input  state
  );

  modport slave (
`ifdef CPU_RUN_CTRL_CYCLE_CNT_EN
    output cycle_cnt,
`endif
    input  go,
    input  stop,
    input  step,
    input  halt_req,
    input  freq_sel,
    output cpu_ce,
    output running,
    output halted,
    output state
  );
endinterface

// File: rtl/cpu_run_ctrl.sv
// Run-control sequencer: single-clock cpu_ce enable with IDLE/RUN/STEP/HALT modes.
// CPU_RUN_CTRL_CYCLE_CNT_EN adds a 32-bit count of cpu_ce pulses on bus.cycle_cnt.
module cpu_run_ctrl #(
  parameter int unsigned DIV0 = 4,
  parameter int unsigned DIV1 = 100,
  parameter int unsigned DIV2 = 1000,
  parameter int unsigned DIV3 = 50000000
) (
  input  logic           clk,
  input  logic           rst_n,
  cpu_run_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2,
    HALT = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        cpu_ce_q, cpu_ce_d;
  logic        go_dly_q, go_dly_d;
  logic        stop_dly_q, stop_dly_d;
  logic        step_dly_q, step_dly_d;
  logic        resume_mask_q, resume_mask_d;

  logic        go_rise;
  logic        stop_rise;
  logic        step_rise;
  logic [31:0] div;
  logic        wrap;

  assign go_rise   = bus.go   & ~go_dly_q;
  assign stop_rise = bus.stop & ~stop_dly_q;
  assign step_rise = bus.step & ~step_dly_q;

  always_comb begin
    div = DIV0;
    case (bus.freq_sel)
      2'd0:    div = DIV0;
      2'd1:    div = DIV1;
      2'd2:    div = DIV2;
      default: div = DIV3;
    endcase
  end

  // >= rather than == so a freq_sel drop below the current count wraps at once
  assign wrap = (cnt_q >= (div - 32'd1));

  always_comb begin
    state_d       = state_q;
    cnt_d         = '0;
    cpu_ce_d      = 1'b0;
    resume_mask_d = 1'b0;
    go_dly_d      = bus.go;
    stop_dly_d    = bus.stop;
    step_dly_d    = bus.step;

    case (state_q)
      IDLE: begin
        if (go_rise) begin
          state_d = RUN;
        end else if (step_rise) begin
          state_d  = STEP;
          cpu_ce_d = 1'b1;
        end
      end

      RUN: begin
        // halt_req is ignored for one cycle after resume so the CPU can leave the syscall
        if (bus.halt_req && !resume_mask_q) begin
          state_d = HALT;
        end else if (stop_rise) begin
          state_d = IDLE;
        end else if (wrap) begin
          cpu_ce_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      STEP: begin
        state_d = IDLE;
      end

      HALT: begin
        if (go_rise) begin
          state_d       = RUN;
          cpu_ce_d      = 1'b1;
          resume_mask_d = 1'b1;
        end else if (stop_rise) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      cpu_ce_q      <= 1'b0;
      go_dly_q      <= 1'b0;
      stop_dly_q    <= 1'b0;
      step_dly_q    <= 1'b0;
      resume_mask_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      cpu_ce_q      <= cpu_ce_d;
      go_dly_q      <= go_dly_d;
      stop_dly_q    <= stop_dly_d;
      step_dly_q    <= step_dly_d;
      resume_mask_q <= resume_mask_d;
    end
  end

  assign bus.cpu_ce  = cpu_ce_q;
  assign bus.running = (state_q == RUN);
  assign bus.halted  = (state_q == HALT);
  assign bus.state   = state_q;

`ifdef CPU_RUN_CTRL_CYCLE_CNT_EN
  logic [31:0] cycle_cnt_q, cycle_cnt_d;

  always_comb begin
    cycle_cnt_d = cycle_cnt_q + {31'd0, cpu_ce_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt_q <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
    end
  end

  assign bus.cycle_cnt = cycle_cnt_q;
`endif

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed self-checking bench for cpu_run_ctrl (DIV0=4, DIV1=100).
// Honours CPU_RUN_CTRL_CYCLE_CNT_EN for the cycle_cnt checks.
module tb_cpu_run_ctrl;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  cpu_run_ctrl_if bus ();

  cpu_run_ctrl #(
    .DIV0(4),
    .DIV1(100),
    .DIV2(1000),
    .DIV3(50000000)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge, away from the active edge
  task automatic applyStimulus(input logic go, input logic stop, input logic step,
                               input logic halt_req, input logic [1:0] freq_sel);
    bus.go       = go;
    bus.stop     = stop;
    bus.step     = step;
    bus.halt_req = halt_req;
    bus.freq_sel = freq_sel;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    repeat (3) @(negedge clk);
    checks++;
    if (bus.state !== 2'd0) begin
      errors++; $display("[TB] FAIL reset_state: got %0d expected 0", bus.state);
    end
    checks++;
    if (bus.cpu_ce !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_ce: got %0b expected 0", bus.cpu_ce);
    end
    checks++;
    if (bus.running !== 1'b0 || bus.halted !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_flags: got running=%0b halted=%0b expected 0 0", bus.running, bus.halted);
    end
`ifdef CPU_RUN_CTRL_CYCLE_CNT_EN
    checks++;
    if (bus.cycle_cnt !== 32'd0) begin
      errors++; $display("[TB] FAIL reset_cycle_cnt: got %0d expected 0", bus.cycle_cnt);
    end
`endif
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_step();
    for (int s = 0; s < 3; s++) begin
      bus.step = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.state !== 2'd2 || bus.cpu_ce !== 1'b1) begin
        errors++; $display("[TB] FAIL step_pulse %0d: got state=%0d ce=%0b expected state=2 ce=1", s, bus.state, bus.cpu_ce);
      end
      bus.step = 1'b0;
      for (int i = 0; i < 9; i++) begin
        @(negedge clk);
        checks++;
        if (bus.state !== 2'd0 || bus.cpu_ce !== 1'b0) begin
          errors++; $display("[TB] FAIL step_idle %0d.%0d: got state=%0d ce=%0b expected state=0 ce=0", s, i, bus.state, bus.cpu_ce);
        end
      end
    end
`ifdef CPU_RUN_CTRL_CYCLE_CNT_EN
    checks++;
    if (bus.cycle_cnt !== 32'd3) begin
      errors++; $display("[TB] FAIL step_cycle_cnt: got %0d expected 3", bus.cycle_cnt);
    end
`endif
  endtask

  task automatic test_run_div0();
    logic exp_ce;
    bus.freq_sel = 2'd0;
    bus.go = 1'b1;
    for (int i = 1; i <= 13; i++) begin
      @(negedge clk);
      exp_ce = (i >= 5) && ((i - 1) % 4 == 0);
      checks++;
      if (bus.cpu_ce !== exp_ce) begin
        errors++; $display("[TB] FAIL run_ce cycle %0d: got %0b expected %0b", i, bus.cpu_ce, exp_ce);
      end
      if (i == 1) begin
        checks++;
        if (bus.running !== 1'b1 || bus.state !== 2'd1) begin
          errors++; $display("[TB] FAIL run_entry: got running=%0b state=%0d expected 1 1", bus.running, bus.state);
        end
        bus.go = 1'b0;
      end
    end
    bus.stop = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.state !== 2'd0 || bus.cpu_ce !== 1'b0) begin
      errors++; $display("[TB] FAIL run_stop: got state=%0d ce=%0b expected 0 0", bus.state, bus.cpu_ce);
    end
    bus.stop = 1'b0;
  endtask

  task automatic test_halt_resume();
    bus.freq_sel = 2'd0;
    bus.go = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      checks++;
      if (bus.cpu_ce !== 1'b0) begin
        errors++; $display("[TB] FAIL halt_pre_ce %0d: got %0b expected 0", i, bus.cpu_ce);
      end
      if (i == 1) bus.go = 1'b0;
    end
    bus.halt_req = 1'b1;
    for (int i = 5; i <= 7; i++) begin
      @(negedge clk);
      checks++;
      if (bus.cpu_ce !== 1'b0 || bus.halted !== 1'b1 || bus.state !== 2'd3) begin
        errors++; $display("[TB] FAIL halt_hold %0d: got ce=%0b halted=%0b state=%0d expected 0 1 3", i, bus.cpu_ce, bus.halted, bus.state);
      end
    end
    bus.go = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.cpu_ce !== 1'b1 || bus.state !== 2'd1 || bus.running !== 1'b1) begin
      errors++; $display("[TB] FAIL resume_pulse: got ce=%0b state=%0d running=%0b expected 1 1 1", bus.cpu_ce, bus.state, bus.running);
    end
    bus.go = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.state !== 2'd1 || bus.cpu_ce !== 1'b0) begin
      errors++; $display("[TB] FAIL resume_mask: got state=%0d ce=%0b expected 1 0", bus.state, bus.cpu_ce);
    end
    bus.halt_req = 1'b0;
    for (int i = 10; i <= 12; i++) begin
      @(negedge clk);
      checks++;
      if (bus.cpu_ce !== (i == 12)) begin
        errors++; $display("[TB] FAIL resume_period %0d: got %0b expected %0b", i, bus.cpu_ce, (i == 12));
      end
    end
    bus.stop = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.state !== 2'd0) begin
      errors++; $display("[TB] FAIL resume_stop: got state=%0d expected 0", bus.state);
    end
    bus.stop = 1'b0;
  endtask

  task automatic test_freq_switch();
    logic exp_ce;
    bus.freq_sel = 2'd1;
    bus.go = 1'b1;
    for (int i = 1; i <= 70; i++) begin
      @(negedge clk);
      exp_ce = (i >= 62) && ((i - 62) % 4 == 0);
      checks++;
      if (bus.cpu_ce !== exp_ce) begin
        errors++; $display("[TB] FAIL freq_ce cycle %0d: got %0b expected %0b", i, bus.cpu_ce, exp_ce);
      end
      if (i == 1) bus.go = 1'b0;
      if (i == 61) bus.freq_sel = 2'd0;
    end
    bus.stop = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.state !== 2'd0) begin
      errors++; $display("[TB] FAIL freq_stop: got state=%0d expected 0", bus.state);
    end
    bus.stop = 1'b0;
  endtask

  task automatic test_stop_go_same();
    bus.freq_sel = 2'd0;
    bus.go = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      if (i == 1) bus.go = 1'b0;
    end
    @(negedge clk);
    bus.go = 1'b1;
    bus.stop = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.state !== 2'd0 || bus.cpu_ce !== 1'b0) begin
      errors++; $display("[TB] FAIL stop_go_edge: got state=%0d ce=%0b expected 0 0", bus.state, bus.cpu_ce);
    end
    bus.stop = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (bus.state !== 2'd0 || bus.cpu_ce !== 1'b0) begin
        errors++; $display("[TB] FAIL go_held %0d: got state=%0d ce=%0b expected 0 0", i, bus.state, bus.cpu_ce);
      end
    end
    bus.go = 1'b0;
    @(negedge clk);
    bus.go = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.state !== 2'd1) begin
      errors++; $display("[TB] FAIL go_rearm: got state=%0d expected 1", bus.state);
    end
    bus.go = 1'b0;
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    bus.freq_sel = 2'd0;
    bus.go = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      if (i == 1) bus.go = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.state !== 2'd0 || bus.cpu_ce !== 1'b0 || bus.running !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_async: got state=%0d ce=%0b running=%0b expected 0 0 0", bus.state, bus.cpu_ce, bus.running);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (bus.state !== 2'd0 || bus.cpu_ce !== 1'b0) begin
        errors++; $display("[TB] FAIL post_reset_quiet %0d: got state=%0d ce=%0b expected 0 0", i, bus.state, bus.cpu_ce);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_step();
    test_run_div0();
    test_halt_resume();
    test_freq_switch();
    test_stop_go_same();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
